// File: rtl/dcm_ctrl.sv
// dcm_ctrl: sequences DCM reset pulses, lock-timeout retries and stable-lock release
// of the system reset for the generated clock domain.
module dcm_ctrl #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    output logic       dcmReset,
    output logic       sysReset,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retries
);
    localparam int MAXC = LOCK_TIMEOUT > STABLE_CYCLES ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic [2:0] {PULSE, WAIT, STABLE, RUN, FAIL} state_t;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    sync;
    logic [2:0]    retries_nxt;
    logic          lock_s, timeout;
    assign lock_s  = sync[1];
    assign timeout = cnt == CW'(LOCK_TIMEOUT - 1);
    // A timeout on the last WAIT cycle wins even if lock arrives in that same cycle
    always_comb begin
        state_nxt   = state;
        retries_nxt = retries;
        case (state)
            PULSE:   state_nxt = cnt == CW'(RST_CYCLES - 1) ? WAIT : PULSE;
            WAIT: begin
                if (timeout) begin
                    state_nxt   = retries < 3'(MAX_RETRY) ? PULSE : FAIL;
                    retries_nxt = retries < 3'(MAX_RETRY) ? retries + 3'd1 : retries;
                end else if (lock_s) begin
                    state_nxt = STABLE;
                end
            end
            STABLE:  state_nxt = !lock_s ? PULSE : cnt == CW'(STABLE_CYCLES - 1) ? RUN : STABLE;
            RUN:     state_nxt = lock_s ? RUN : PULSE;
            default: state_nxt = FAIL;
        endcase
    end
    // Outputs are registered from the next state so they change on the same edge as state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= PULSE;
            cnt      <= '0;
            retries  <= '0;
            sync     <= '0;
            dcmReset <= 1'b1;
            sysReset <= 1'b1;
            ready    <= 1'b0;
            fail     <= 1'b0;
        end else begin
            sync     <= {sync[0], locked};
            state    <= state_nxt;
            retries  <= retries_nxt;
            cnt      <= (state_nxt != state || state == RUN || state == FAIL) ? '0 : cnt + CW'(1);
            dcmReset <= state_nxt == PULSE;
            sysReset <= state_nxt != RUN;
            ready    <= state_nxt == RUN;
            fail     <= state_nxt == FAIL;
        end
    end
endmodule

// File: tb/tb_dcm_ctrl.sv
// tb_dcm_ctrl: vector table, hand-written corner sequences and randomized lock
// patterns checked against a phase/duration model of the DCM controller.
module tb_dcm_ctrl;
    localparam int RST = 4, LT = 32, SC = 8, MR = 2;
    localparam int M_PULSE = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_FAIL = 4;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic locked = 1'b0;
    logic dcmReset, sysReset, ready, fail;
    logic [2:0] retries;
    int checks = 0, errors = 0;
    int m_ph, m_age, m_ret;
    logic hist[$];

    dcm_ctrl #(.RST_CYCLES(RST), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRY(MR)) dut (
        .clock(clock), .reset(reset), .locked(locked), .dcmReset(dcmReset),
        .sysReset(sysReset), .ready(ready), .fail(fail), .retries(retries));

    always #5 clock = ~clock;

    typedef struct {
        logic lk;
        int n;
        logic dcm, sys, rdy, fl;
        logic [2:0] ret;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_ph = M_PULSE;
        m_age = 0;
        m_ret = 0;
        hist = {1'b0, 1'b0};
    endfunction

    // lock is seen two edges after it is sampled; m_age is cycles already spent in the phase
    function automatic void model_step(input logic l);
        logic ls;
        int nph;
        ls = hist[1];
        nph = m_ph;
        if (m_ph == M_PULSE && m_age + 1 == RST) nph = M_WAIT;
        else if (m_ph == M_WAIT && m_age + 1 == LT) begin
            if (m_ret < MR) begin m_ret++; nph = M_PULSE; end
            else nph = M_FAIL;
        end
        else if (m_ph == M_WAIT && ls) nph = M_STABLE;
        else if ((m_ph == M_STABLE || m_ph == M_RUN) && !ls) nph = M_PULSE;
        else if (m_ph == M_STABLE && m_age + 1 == SC) nph = M_RUN;
        m_age = (nph == m_ph) ? m_age + 1 : 0;
        m_ph = nph;
        hist.push_front(l);
        void'(hist.pop_back());
    endfunction

    task automatic tick(input logic l);
        locked = l;
        @(posedge clock);
        @(negedge clock);
        model_step(l);
        chk("model_dcmReset", dcmReset, m_ph == M_PULSE);
        chk("model_sysReset", sysReset, m_ph != M_RUN);
        chk("model_ready", ready, m_ph == M_RUN);
        chk("model_fail", fail, m_ph == M_FAIL);
        chk("model_retries", retries, m_ret);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_dcmReset"}, dcmReset, 1);
        chk({nm, "_sysReset"}, sysReset, 1);
        chk({nm, "_ready"}, ready, 0);
        chk({nm, "_fail"}, fail, 0);
        chk({nm, "_retries"}, retries, 0);
    endtask

    task automatic do_reset();
        locked = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk_reset_vals("reset_hold");
        reset = 1'b0;
        model_reset();
    endtask

    task automatic async_reset(input string nm);
        #2 reset = 1'b1;
        #1 chk_reset_vals(nm);
        locked = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic lv;
        int len;
        // scenario 1 then a one-cycle lock drop in RUN (scenario 3)
        tbl.push_back(vec_t'{1'b0, 3,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b0, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b0, 9,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 5,  1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 3,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 1,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 8,  1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
        tbl.push_back(vec_t'{1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0, 3'd0});
        do_reset();
        foreach (tbl[i]) begin
            repeat (tbl[i].n) tick(tbl[i].lk);
            chk($sformatf("vec%0d_dcmReset", i), dcmReset, tbl[i].dcm);
            chk($sformatf("vec%0d_sysReset", i), sysReset, tbl[i].sys);
            chk($sformatf("vec%0d_ready", i), ready, tbl[i].rdy);
            chk($sformatf("vec%0d_fail", i), fail, tbl[i].fl);
            chk($sformatf("vec%0d_retries", i), retries, tbl[i].ret);
        end
        async_reset("run_async_reset");
        // scenario 2: no lock ever
        do_reset();
        repeat (35) tick(1'b0);
        chk("s2_first_wait_retries", retries, 0);
        chk("s2_first_wait_dcm", dcmReset, 0);
        tick(1'b0);
        chk("s2_retry1", retries, 1);
        chk("s2_retry1_dcm", dcmReset, 1);
        repeat (36) tick(1'b0);
        chk("s2_retry2", retries, 2);
        repeat (35) tick(1'b0);
        chk("s2_last_wait_fail", fail, 0);
        tick(1'b0);
        chk("s2_fail", fail, 1);
        chk("s2_fail_dcm", dcmReset, 0);
        repeat (20) tick(1'b1);
        chk("s2_fail_sticky", fail, 1);
        chk("s2_fail_retries", retries, 2);
        async_reset("fail_async_reset");
        // scenario 4: glitch at STABLE cycle 5
        do_reset();
        repeat (8) tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        chk("s4_pre_drop_dcm", dcmReset, 0);
        tick(1'b1);
        chk("s4_back_to_pulse", dcmReset, 1);
        repeat (12) tick(1'b1);
        chk("s4_no_early_release", ready, 0);
        tick(1'b1);
        chk("s4_release", ready, 1);
        chk("s4_retries", retries, 0);
        // scenario 6: lock seen on final timeout cycle
        do_reset();
        repeat (33) tick(1'b0);
        repeat (2) tick(1'b1);
        chk("s6_pre_timeout", retries, 0);
        tick(1'b1);
        chk("s6_timeout_wins", retries, 1);
        chk("s6_timeout_pulse", dcmReset, 1);
        repeat (20) tick(1'b1);
        // randomized lock patterns
        repeat (4) begin
            do_reset();
            for (int c = 0; c < 700; c += len) begin
                lv = $urandom_range(0, 3) != 0;
                len = lv ? $urandom_range(1, 40) : $urandom_range(1, ($urandom_range(0, 3) == 0) ? 110 : 3);
                repeat (len) tick(lv);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
